// File: rtl/vc_packetizer_pkg.sv
// Shared constants for the VC packetizer: FSM encoding, channel field layout and width helpers.
package vc_packetizer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } vcp_state_e;

    function automatic int clogb(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    // channel_out = {link_active, flit_valid, head, tail, vc, data}, offsets counted from bit 0
    function automatic int vc_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int tail_pos(input int data_w, input int vc_w);
        return data_w + vc_w;
    endfunction

    function automatic int head_pos(input int data_w, input int vc_w);
        return data_w + vc_w + 1;
    endfunction

    function automatic int valid_pos(input int data_w, input int vc_w);
        return data_w + vc_w + 2;
    endfunction

    function automatic int link_pos(input int data_w, input int vc_w);
        return data_w + vc_w + 3;
    endfunction

    // three control bits (flit_valid, head, tail) plus the optional link bit
    function automatic int channel_w(input int link_w, input int vc_w, input int data_w);
        return link_w + 3 + vc_w + data_w;
    endfunction

    function automatic int flow_ctrl_w(input int vc_w);
        return 1 + vc_w;
    endfunction

endpackage

// File: rtl/vc_packetizer_if.sv
// Packet/payload handshake, credit return and channel bundle between a packet source and the packetizer.
interface vc_packetizer_if #(
    parameter int num_vcs            = 4,
    parameter int flit_data_width    = 64,
    parameter int min_payload_length = 1,
    parameter int max_payload_length = 4,
    parameter int addr_width         = 4,
    parameter int enable_link_pm     = 1
);
    import vc_packetizer_pkg::*;

    localparam int vc_idx_width    = clogb(num_vcs);
    localparam int length_width    = clogb(max_payload_length - min_payload_length + 1);
    localparam int link_ctrl_width = enable_link_pm;
    localparam int channel_width   = channel_w(link_ctrl_width, vc_idx_width, flit_data_width);
    localparam int flow_width      = flow_ctrl_w(vc_idx_width);

    logic                       pkt_valid;
    logic                       pkt_ready;
    logic [addr_width-1:0]      pkt_dest;
    logic [vc_idx_width-1:0]    pkt_vc;
    logic [length_width-1:0]    pkt_length;
    logic                       data_valid;
    logic                       data_ready;
    logic [flit_data_width-1:0] data_in;
    logic [flow_width-1:0]      flow_ctrl_in;
    logic [channel_width-1:0]   channel_out;
    logic [num_vcs-1:0]         credits_avail;
    logic                       error;

    modport master (
        output pkt_valid, pkt_dest, pkt_vc, pkt_length, data_valid, data_in, flow_ctrl_in,
        input  pkt_ready, data_ready, channel_out, credits_avail, error
    );

    modport slave (
        input  pkt_valid, pkt_dest, pkt_vc, pkt_length, data_valid, data_in, flow_ctrl_in,
        output pkt_ready, data_ready, channel_out, credits_avail, error
    );

endinterface

// File: rtl/vcp_credit_counter.sv
// Per-VC downstream credit counter: starts full, saturates at both ends, flags a return into a full buffer.
module vcp_credit_counter #(
    parameter int buffer_size  = 8,
    parameter int credit_width = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    send,
    input  logic                    ret,
    output logic [credit_width-1:0] count,
    output logic                    overflow
);
    localparam logic [credit_width-1:0] full = credit_width'(buffer_size);

    // a send in the same cycle consumes the slot the return frees, so that pair is never an overflow
    assign overflow = ret && !send && (count == full);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= full;
        end else if (send && !ret && (count != '0)) begin
            count <= count - 1'b1;
        end else if (ret && !send && (count != full)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/vc_packetizer.sv
// Turns a header + payload stream into head/body/tail flits on one VC, gated by per-VC credits.
//   state | meaning
//   IDLE  | ready for a new header
//   HEAD  | header latched, waiting for a credit to emit the head flit
//   BODY  | forwarding payload flits until the tail
module vc_packetizer #(
    parameter int num_vcs            = 4,
    parameter int buffer_size        = 8,
    parameter int flit_data_width    = 64,
    parameter int min_payload_length = 1,
    parameter int max_payload_length = 4,
    parameter int addr_width         = 4,
    parameter int enable_link_pm     = 1
) (
    input  logic          clk,
    input  logic          reset,
    vc_packetizer_if.slave bus
);
    import vc_packetizer_pkg::*;

    localparam int vc_idx_width = clogb(num_vcs);
    localparam int length_width = clogb(max_payload_length - min_payload_length + 1);
    localparam int credit_width = clogb(buffer_size + 1);
    localparam int rem_width    = clogb(max_payload_length);
    localparam int pad_width    = flit_data_width - addr_width - length_width;

    vcp_state_e                 state;
    logic [vc_idx_width-1:0]    cur_vc;
    logic [addr_width-1:0]      cur_dest;
    logic [length_width-1:0]    cur_len;
    logic [rem_width-1:0]       rem;
    logic                       flit_valid_q;
    logic                       head_q;
    logic                       tail_q;
    logic                       link_q;
    logic                       error_q;
    logic [vc_idx_width-1:0]    vc_q;
    logic [flit_data_width-1:0] data_q;

    logic [credit_width-1:0]    cnt [num_vcs];
    logic [num_vcs-1:0]         send;
    logic [num_vcs-1:0]         ret;
    logic [num_vcs-1:0]         overflow;
    logic [num_vcs-1:0]         below_full;
    logic [num_vcs-1:0]         avail;
    logic                       ret_valid;
    logic [vc_idx_width-1:0]    ret_vc;
    logic                       cur_has_credit;
    logic                       pkt_fire;
    logic                       vc_bad;
    logic                       body_fire;
    logic                       flit_fire;
    logic                       link_now;

    assign ret_valid      = bus.flow_ctrl_in[vc_idx_width];
    assign ret_vc         = bus.flow_ctrl_in[vc_idx_width-1:0];
    assign cur_has_credit = (cnt[cur_vc] != '0);
    assign pkt_fire       = bus.pkt_valid && (state == ST_IDLE);
    assign vc_bad         = pkt_fire && (int'(bus.pkt_vc) >= num_vcs);
    assign body_fire      = (state == ST_BODY) && bus.data_valid && cur_has_credit;
    assign flit_fire      = ((state == ST_HEAD) && cur_has_credit) || body_fire;
    assign link_now       = (state != ST_IDLE) || (|below_full);

    for (genvar v = 0; v < num_vcs; v++) begin : g_vc
        assign send[v]       = flit_fire && (cur_vc == vc_idx_width'(v));
        assign ret[v]        = ret_valid && (ret_vc == vc_idx_width'(v));
        assign below_full[v] = (cnt[v] != credit_width'(buffer_size));
        assign avail[v]      = (cnt[v] != '0);

        vcp_credit_counter #(
            .buffer_size  (buffer_size),
            .credit_width (credit_width)
        ) u_credit (
            .clk      (clk),
            .reset    (reset),
            .send     (send[v]),
            .ret      (ret[v]),
            .count    (cnt[v]),
            .overflow (overflow[v])
        );
    end

    assign bus.pkt_ready     = (state == ST_IDLE);
    assign bus.data_ready    = (state == ST_BODY) && cur_has_credit;
    assign bus.credits_avail = avail;
    assign bus.error         = error_q;

    if (enable_link_pm != 0) begin : g_link
        assign bus.channel_out = {link_q, flit_valid_q, head_q, tail_q, vc_q, data_q};
    end else begin : g_no_link
        assign bus.channel_out = {flit_valid_q, head_q, tail_q, vc_q, data_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cur_vc       <= '0;
            cur_dest     <= '0;
            cur_len      <= '0;
            rem          <= '0;
            flit_valid_q <= 1'b0;
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            link_q       <= 1'b0;
            error_q      <= 1'b0;
            vc_q         <= '0;
            data_q       <= '0;
        end else begin
            flit_valid_q <= 1'b0;
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            link_q       <= link_now;
            if (vc_bad || (|overflow)) begin
                error_q <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (pkt_fire) begin
                        cur_vc   <= vc_bad ? '0 : bus.pkt_vc;
                        cur_dest <= bus.pkt_dest;
                        cur_len  <= bus.pkt_length;
                        state    <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (cur_has_credit) begin
                        flit_valid_q <= 1'b1;
                        head_q       <= 1'b1;
                        vc_q         <= cur_vc;
                        data_q       <= {cur_dest, cur_len, {pad_width{1'b0}}};
                        // rem counts the body flits still to send after the current one
                        rem          <= rem_width'(cur_len) + rem_width'(min_payload_length - 1);
                        state        <= ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (body_fire) begin
                        flit_valid_q <= 1'b1;
                        tail_q       <= (rem == '0);
                        vc_q         <= cur_vc;
                        data_q       <= bus.data_in;
                        if (rem == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            rem <= rem - 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vc_packetizer.sv
// Bench for vc_packetizer: packet table with a flit scoreboard, plus credit, error and reset sequences.
module tb_vc_packetizer;

    localparam int VALID_BIT = 68;
    localparam int HEAD_BIT  = 67;
    localparam int TAIL_BIT  = 66;
    localparam int LINK_BIT  = 69;

    typedef struct {
        logic        head;
        logic        tail;
        logic [1:0]  vc;
        logic [63:0] data;
        int          cyc;
    } flit_t;

    typedef struct {
        logic [1:0] vc;
        logic [3:0] dest;
        logic [1:0] len;
        int         exp_cnt;
        logic [3:0] exp_avail;
    } pkt_vec_t;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    int    cyc = 0;
    int    n_vec = 0;
    int    n_err = 0;
    int    last_tail_cyc = -1;
    int    head_gap = -1;
    logic [1:0] tb_vc = 2'd0;
    flit_t exp_q [$];
    pkt_vec_t tbl [5];

    vc_packetizer_if bus ();

    vc_packetizer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        flit_t e;
        if (reset && bus.channel_out[VALID_BIT]) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_flit: got %h at cyc %0d, expected no flit", bus.channel_out, cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.channel_out[HEAD_BIT] !== e.head || bus.channel_out[TAIL_BIT] !== e.tail ||
                    bus.channel_out[65:64] !== e.vc || bus.channel_out[63:0] !== e.data ||
                    (e.cyc >= 0 && cyc != e.cyc)) begin
                    n_err++;
                    $display("FAIL flit: got h%0b t%0b vc%0d d=%h cyc%0d, expected h%0b t%0b vc%0d d=%h cyc%0d",
                             bus.channel_out[HEAD_BIT], bus.channel_out[TAIL_BIT], bus.channel_out[65:64],
                             bus.channel_out[63:0], cyc, e.head, e.tail, e.vc, e.data, e.cyc);
                end
            end
            if (bus.channel_out[HEAD_BIT] && last_tail_cyc >= 0) head_gap = cyc - last_tail_cyc;
            if (bus.channel_out[TAIL_BIT]) last_tail_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic hdr(input logic [1:0] vc, input logic [3:0] dest, input logic [1:0] len);
        int t = 0;
        flit_t f;
        bus.pkt_valid  = 1'b1;
        bus.pkt_vc     = vc;
        bus.pkt_dest   = dest;
        bus.pkt_length = len;
        while (!bus.pkt_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.pkt_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL hdr_timeout: pkt_ready %0b, expected 1", bus.pkt_ready);
        end else begin
            f.head = 1'b1;
            f.tail = 1'b0;
            f.vc   = vc;
            f.data = {dest, len, 58'd0};
            f.cyc  = -1;
            exp_q.push_back(f);
            tb_vc = vc;
        end
        @(negedge clk);
        bus.pkt_valid = 1'b0;
    endtask

    task automatic beat(input logic [63:0] d, input logic tail, input logic with_ret);
        int t = 0;
        flit_t f;
        bus.data_valid = 1'b1;
        bus.data_in    = d;
        while (!bus.data_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.data_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_timeout: data_ready %0b, expected 1", bus.data_ready);
        end else begin
            if (with_ret) bus.flow_ctrl_in = {1'b1, tb_vc};
            f.head = 1'b0;
            f.tail = tail;
            f.vc   = tb_vc;
            f.data = d;
            f.cyc  = cyc + 1;
            exp_q.push_back(f);
        end
        @(negedge clk);
        bus.data_valid   = 1'b0;
        bus.flow_ctrl_in = '0;
    endtask

    task automatic send_pkt(input logic [1:0] vc, input logic [3:0] dest, input logic [1:0] len);
        hdr(vc, dest, len);
        for (int i = 0; i <= int'(len); i++) beat({$urandom, $urandom}, (i == int'(len)), 1'b0);
    endtask

    task automatic ret_credit(input logic [1:0] vc);
        bus.flow_ctrl_in = {1'b1, vc};
        @(negedge clk);
        bus.flow_ctrl_in = '0;
    endtask

    task automatic do_reset();
        bus.pkt_valid    = 1'b0;
        bus.data_valid   = 1'b0;
        bus.flow_ctrl_in = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        last_tail_cyc = -1;
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] d;
        bus.pkt_valid    = 1'b0;
        bus.pkt_dest     = '0;
        bus.pkt_vc       = '0;
        bus.pkt_length   = '0;
        bus.data_valid   = 1'b0;
        bus.data_in      = '0;
        bus.flow_ctrl_in = '0;

        tbl[0] = '{2'd2, 4'b0001, 2'd3, 3, 4'hF};
        tbl[1] = '{2'd0, 4'h5,    2'd0, 6, 4'hF};
        tbl[2] = '{2'd1, 4'hA,    2'd1, 5, 4'hF};
        tbl[3] = '{2'd3, 4'hF,    2'd2, 4, 4'hF};
        tbl[4] = '{2'd2, 4'h3,    2'd1, 0, 4'b1011};

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_pkt_ready", bus.pkt_ready, 1);
        check("rst_data_ready", bus.data_ready, 0);
        check("rst_credits_avail", bus.credits_avail, 4'hF);
        check("rst_error", bus.error, 0);
        check("rst_channel_out", bus.channel_out, 0);

        // back-to-back packets: credit count and head-after-tail spacing per packet
        for (int k = 0; k < 5; k++) begin
            head_gap = -1;
            send_pkt(tbl[k].vc, tbl[k].dest, tbl[k].len);
            check("credit_count", dut.cnt[tbl[k].vc], tbl[k].exp_cnt);
            check("credits_avail", bus.credits_avail, tbl[k].exp_avail);
            if (k > 0) check("b2b_head_gap", head_gap, 2);
        end
        check("link_active_busy", bus.channel_out[LINK_BIT], 1);
        check("table_no_error", bus.error, 0);

        // credit exhaustion on VC 0: 9 flits requested, 8 go out, one return releases the 9th
        do_reset();
        send_pkt(2'd0, 4'h2, 2'd3);
        hdr(2'd0, 4'h7, 2'd2);
        beat({$urandom, $urandom}, 1'b0, 1'b0);
        beat({$urandom, $urandom}, 1'b0, 1'b0);
        d = {$urandom, $urandom};
        bus.data_valid = 1'b1;
        bus.data_in    = d;
        for (int i = 0; i < 4; i++) begin
            check("stall_data_ready", bus.data_ready, 0);
            @(negedge clk);
        end
        check("stall_avail0", bus.credits_avail[0], 0);
        ret_credit(2'd0);
        beat(d, 1'b1, 1'b0);
        check("after_return_cnt0", dut.cnt[0], 0);
        repeat (2) @(negedge clk);
        check("exhaust_drained", exp_q.size(), 0);

        // send and return on VC 1 in the same cycle
        do_reset();
        hdr(2'd1, 4'h3, 2'd0);
        beat({$urandom, $urandom}, 1'b1, 1'b1);
        check("same_cycle_cnt1", dut.cnt[1], 7);
        check("same_cycle_no_error", bus.error, 0);

        // return into a full VC 3 sets a sticky error
        do_reset();
        ret_credit(2'd3);
        check("overflow_error", bus.error, 1);
        check("overflow_saturated", dut.cnt[3], 8);
        send_pkt(2'd3, 4'h9, 2'd2);
        check("overflow_cnt3_after", dut.cnt[3], 4);
        check("error_sticky_traffic", bus.error, 1);
        send_pkt(2'd2, 4'h6, 2'd0);
        ret_credit(2'd2);
        check("error_sticky_return", bus.error, 1);

        // reset during the second body flit
        do_reset();
        hdr(2'd0, 4'h4, 2'd3);
        beat({$urandom, $urandom}, 1'b0, 1'b0);
        bus.data_valid = 1'b1;
        bus.data_in    = {$urandom, $urandom};
        check("body2_ready", bus.data_ready, 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_reset_channel", bus.channel_out, 0);
        bus.data_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_pkt_ready", bus.pkt_ready, 1);
        check("post_reset_data_ready", bus.data_ready, 0);
        check("post_reset_avail", bus.credits_avail, 4'hF);
        for (int v = 0; v < 4; v++) check("post_reset_cnt", dut.cnt[v], 8);
        check("post_reset_error", bus.error, 0);
        repeat (4) @(negedge clk);
        check("post_reset_link", bus.channel_out[LINK_BIT], 0);
        check("post_reset_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
